// File: rtl/seg_scan_pkg.sv
// Shared constants for the watch 7-segment scan bus: segment patterns, digit codes
// and a strobe classifier used by the receive-side decoder.
package seg_scan_pkg;

    localparam int NUM_SLOTS = 7;

    localparam logic [3:0] CODE_AM    = 4'hA;
    localparam logic [3:0] CODE_PM    = 4'hB;
    localparam logic [3:0] CODE_BLANK = 4'hE;
    localparam logic [3:0] CODE_INV   = 4'hF;

    // Segment order g..a in bits [6:0]; the watch encoder uses the same table.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h27;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_AM    = 7'h77;
    localparam logic [6:0] SEG_PM    = 7'h73;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        COM_IDLE,
        COM_ONEHOT,
        COM_MULTI
    } com_kind_e;

    typedef struct packed {
        com_kind_e  kind;
        logic [2:0] idx;
    } com_info_t;

    // A lone zero on bit 7 is not a digit slot, so it is treated like an idle sample.
    function automatic com_info_t com_classify(input logic [7:0] com);
        com_info_t   r;
        int unsigned nz;
        r.kind = COM_IDLE;
        r.idx  = '0;
        nz     = 0;
        for (int i = 0; i < 8; i++) begin
            if (!com[i]) begin
                nz++;
                r.idx = 3'(i);
            end
        end
        if (nz > 1)
            r.kind = COM_MULTI;
        else if (nz == 1 && r.idx != 3'd7)
            r.kind = COM_ONEHOT;
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7_decode.sv
// Combinational 7-segment pattern to 4-bit digit code; unknown patterns map to CODE_INV.
module seg7_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] code_o
);

    always_comb begin
        code_o = CODE_INV;
        case (pattern_i)
            SEG_0:     code_o = 4'd0;
            SEG_1:     code_o = 4'd1;
            SEG_2:     code_o = 4'd2;
            SEG_3:     code_o = 4'd3;
            SEG_4:     code_o = 4'd4;
            SEG_5:     code_o = 4'd5;
            SEG_6:     code_o = 4'd6;
            SEG_7:     code_o = 4'd7;
            SEG_8:     code_o = 4'd8;
            SEG_9:     code_o = 4'd9;
            SEG_AM:    code_o = CODE_AM;
            SEG_PM:    code_o = CODE_PM;
            SEG_BLANK: code_o = CODE_BLANK;
            default:   code_o = CODE_INV;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Scan-bus readback: registers strobes/segments, tracks the scan slot, decodes digits,
// commits per-frame presence and flags digits whose presence toggles at blink rate.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int BLINK_MIN = 32,
    parameter int BLINK_MAX = 100
) (
    input  logic        clk_1k,
    input  logic        rst,
    input  logic [7:0]  com_i,
    input  logic [7:0]  seg_i,
    output logic [27:0] digits_o,
    output logic [6:0]  present_o,
    output logic [6:0]  dp_o,
    output logic [6:0]  blink_o,
    output logic        frame_done_o,
    output logic        sync_err_o
);

    localparam logic [6:0] RUN_MIN = 7'(BLINK_MIN);
    localparam logic [6:0] RUN_MAX = 7'(BLINK_MAX);

    logic [7:0]                     com_q, seg_q;
    logic [2:0]                     slot_q, slot_d;
    logic [NUM_SLOTS-1:0][3:0]      digits_q;
    logic [NUM_SLOTS-1:0]           dp_q, fp_q, present_q;
    logic                           frame_done_q, sync_err_q;
    logic [3:0]                     code;
    logic                           strobe, commit;
    com_info_t                      info;

    seg7_decode u_dec (
        .pattern_i (seg_q[6:0]),
        .code_o    (code)
    );

    always_comb begin
        info   = com_classify(com_q);
        strobe = (info.kind == COM_ONEHOT);
        slot_d = strobe ? info.idx : slot_q + 3'd1;
        commit = (slot_d == 3'd7);
    end

    always_ff @(posedge clk_1k or posedge rst) begin
        if (rst) begin
            com_q        <= 8'hFF;
            seg_q        <= 8'h00;
            slot_q       <= 3'd7;
            digits_q     <= {NUM_SLOTS{CODE_BLANK}};
            dp_q         <= '0;
            fp_q         <= '0;
            present_q    <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            com_q        <= com_i;
            seg_q        <= seg_i;
            slot_q       <= slot_d;
            sync_err_q   <= (info.kind == COM_MULTI);
            frame_done_q <= commit;
            if (strobe) begin
                digits_q[info.idx] <= code;
                dp_q[info.idx]     <= seg_q[7];
            end
            // Slot 7 never strobes, so a commit and a presence set cannot collide.
            if (commit) begin
                present_q <= fp_q;
                fp_q      <= '0;
            end else if (strobe) begin
                fp_q[info.idx] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_blink
        logic [6:0] run_q;
        logic       last_q;
        logic       blink_q;

        always_ff @(posedge clk_1k or posedge rst) begin
            if (rst) begin
                run_q   <= '0;
                last_q  <= 1'b0;
                blink_q <= 1'b0;
            end else if (commit) begin
                if (fp_q[k] != last_q) begin
                    blink_q <= (run_q >= RUN_MIN) && (run_q <= RUN_MAX);
                    run_q   <= 7'd1;
                    last_q  <= fp_q[k];
                end else begin
                    if (run_q != 7'h7F)
                        run_q <= run_q + 7'd1;
                    // run_q >= MAX means the incremented run exceeds MAX.
                    if (run_q >= RUN_MAX)
                        blink_q <= 1'b0;
                end
            end
        end

        assign blink_o[k] = blink_q;
    end

    assign digits_o     = digits_q;
    assign present_o    = present_q;
    assign dp_o         = dp_q;
    assign frame_done_o = frame_done_q;
    assign sync_err_o   = sync_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: drives scan frames on negedge, checks decoded
// digits, presence, dp, blink, frame pulses, sync errors and mid-frame reset.
module tb_seg_scan_decoder;

    logic        clk_1k = 1'b0;
    logic        rst;
    logic [7:0]  com, seg;
    logic [27:0] digits;
    logic [6:0]  present, dp, blink;
    logic        frame_done, sync_err;

    logic [6:0]  pat [7];
    logic [6:0]  dpv;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_fd = 0;
    int          fd_gap = 0;
    int          fd_cnt = 0;

    seg_scan_decoder dut (
        .clk_1k       (clk_1k),
        .rst          (rst),
        .com_i        (com),
        .seg_i        (seg),
        .digits_o     (digits),
        .present_o    (present),
        .dp_o         (dp),
        .blink_o      (blink),
        .frame_done_o (frame_done),
        .sync_err_o   (sync_err)
    );

    always #5 clk_1k = ~clk_1k;

    always @(posedge clk_1k) begin
        #1;
        cyc++;
        if (frame_done) begin
            fd_cnt++;
            fd_gap  = cyc - last_fd;
            last_fd = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_slot(input int s, input logic en);
        @(negedge clk_1k);
        if (s < 7) begin
            com = en ? ~(8'd1 << s) : 8'hFF;
            seg = {dpv[s], pat[s]};
        end else begin
            com = 8'hFF;
            seg = 8'h00;
        end
    endtask

    task automatic run_frame(input logic [6:0] en);
        for (int s = 0; s < 8; s++) begin
            if (s < 7) drive_slot(s, en[s]);
            else       drive_slot(s, 1'b0);
        end
    endtask

    task automatic frames(input int n, input logic [6:0] en);
        repeat (n) run_frame(en);
    endtask

    task automatic check_wait();
        repeat (2) @(posedge clk_1k);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run time exceeded, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        com = 8'hFF;
        seg = 8'h00;
        dpv = 7'h00;
        pat[0] = 7'h3F; pat[1] = 7'h6D; pat[2] = 7'h4F; pat[3] = 7'h66;
        pat[4] = 7'h06; pat[5] = 7'h06; pat[6] = 7'h77;

        #12;
        chk("rst_digits", digits, 28'hEEEEEEE);
        chk("rst_flags", {present, dp, blink, frame_done, sync_err}, 0);
        rst = 1'b0;

        // first frame, with a latency probe on slot 0
        drive_slot(0, 1'b1);
        @(posedge clk_1k); #1;
        chk("lat_stage1", digits[3:0], 4'hE);
        drive_slot(1, 1'b1);
        @(posedge clk_1k); #1;
        chk("lat_stage2", digits[3:0], 4'h0);
        for (int s = 2; s < 8; s++) drive_slot(s, s < 7);
        check_wait();
        chk("scan_digits", digits, 28'hA114350);
        chk("scan_present", present, 7'h7F);
        chk("fd_pulse", frame_done, 1'b1);

        dpv = 7'b010_1000;
        run_frame(7'h7F);
        check_wait();
        chk("dp_bits", dp, 7'h28);

        frames(3, 7'h5F);
        check_wait();
        chk("supp_present", present, 7'h5F);
        chk("supp_digits", digits, 28'hA114350);
        chk("supp_blink", blink, 7'h00);
        chk("supp_dp", dp, 7'h28);

        run_frame(7'h7F);
        check_wait();
        chk("restore_present", present, 7'h7F);

        frames(62, 7'h7E);
        run_frame(7'h7F);
        check_wait();
        chk("blink_on", blink, 7'h01);

        frames(62, 7'h7F);
        frames(62, 7'h7E);
        frames(63, 7'h7F);
        frames(62, 7'h7E);
        frames(63, 7'h7F);
        check_wait();
        chk("blink_hold", blink, 7'h01);

        frames(37, 7'h7F);
        check_wait();
        chk("blink_run100", blink, 7'h01);
        frames(1, 7'h7F);
        check_wait();
        chk("blink_run101", blink, 7'h00);

        fd_cnt = 0;
        frames(63, 7'h7F);
        check_wait();
        chk("fd_count", fd_cnt, 63);
        chk("fd_period", fd_gap, 8);
        chk("blink_off", blink, 7'h00);

        @(negedge clk_1k);
        com = 8'hFC;
        seg = 8'h00;
        @(posedge clk_1k); #1;
        chk("sync_early", sync_err, 1'b0);
        @(negedge clk_1k);
        com = 8'hFF;
        @(posedge clk_1k); #1;
        chk("sync_pulse", sync_err, 1'b1);
        @(posedge clk_1k); #1;
        chk("sync_clear", sync_err, 1'b0);
        run_frame(7'h7F);
        check_wait();
        chk("resync_present", present, 7'h7F);
        chk("resync_digits", digits, 28'hA114350);

        pat[2] = 7'h12;
        run_frame(7'h7F);
        check_wait();
        chk("inv_digit", digits[11:8], 4'hF);
        chk("inv_present", present, 7'h7F);

        for (int s = 0; s < 4; s++) drive_slot(s, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_digits", digits, 28'hEEEEEEE);
        chk("midrst_flags", {present, dp, blink, frame_done, sync_err}, 0);
        @(posedge clk_1k);
        drive_slot(4, 1'b1);
        rst = 1'b0;
        for (int s = 5; s < 8; s++) drive_slot(s, s < 7);
        check_wait();
        chk("partial_present", present, 7'h70);
        chk("partial_digits", digits, 28'hA11EEEE);
        chk("partial_dp", dp, 7'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
